// File: rtl/seconds_display_driver.sv
// seconds_display_driver
//
// Takes the seconds counter's binary value (0..59). Each time it is strobed,
// the value goes through a sequential shift-add-3 (double dabble) BCD
// converter. The result drives a two-digit multiplexed 7-segment display.
// Values above 59 are flagged on err, and both digits then show a dash. The
// last in-range BCD digits are kept.
//
// Optional feature macro: SECDISP_LZB_EN
//   Defined:   a tens digit of 0 is blanked (seg = 7'h00) unless err is set.
//   Undefined: a tens digit of 0 is shown as '0' (7'h3F).
//
// Parameters:
//   MUX_LOG2   log2 of the number of cycles each digit is displayed (>= 1).
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   sec_in     [5:0] binary seconds value, sampled when sec_valid is high
//   sec_valid  single-cycle update strobe
//   seg        [6:0] {g,f,e,d,c,b,a}, active high, registered
//   digit_sel  [1:0] one-hot digit enable, bit0 = ones, bit1 = tens, registered
//   bcd_tens   [2:0] last in-range tens digit
//   bcd_ones   [3:0] last in-range ones digit
//   busy       high while a conversion (SHIFT or LOAD) is in progress
//   err        high when the last converted value was greater than 59

module seconds_display_driver #(
    parameter int MUX_LOG2 = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] sec_in,
    input  logic       sec_valid,
    output logic [6:0] seg,
    output logic [1:0] digit_sel,
    output logic [2:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    localparam logic [MUX_LOG2-1:0] MUX_ONE = 1;

    state_t              state_q, state_d;
    logic [5:0]          val_q, val_d;        // value being converted
    logic [5:0]          sh_q, sh_d;          // binary bits still to shift, MSB first
    logic [6:0]          scr_q, scr_d;        // BCD scratch {tens[2:0], ones[3:0]}
    logic [2:0]          cnt_q, cnt_d;        // shift step counter
    logic [5:0]          pend_q, pend_d;      // one-deep pending value
    logic                pend_vld_q, pend_vld_d;
    logic [2:0]          tens_q, tens_d;
    logic [3:0]          ones_q, ones_d;
    logic                err_q, err_d;
    logic [MUX_LOG2-1:0] mux_q, mux_d;
    logic                phase_q, phase_d;    // 0 = ones digit, 1 = tens digit
    logic [6:0]          seg_q, seg_d;
    logic [1:0]          dsel_q, dsel_d;

    logic                start;
    logic [5:0]          start_val;

    // Segment pattern for a decimal digit; codes 10..15 never occur.
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // One double-dabble step: correct each nibble that is >= 5, then shift
    // the next binary bit in at the bottom. For out-of-range inputs the
    // tens nibble can overflow. That result is never loaded.
    function automatic logic [6:0] dabble_step(input logic [6:0] s, input logic b);
        logic [2:0] t;
        logic [3:0] o;
        t = s[6:4];
        o = s[3:0];
        if (t >= 3'd5) t = t + 3'd3;
        if (o >= 4'd5) o = o + 4'd3;
        return {t[1:0], o, b};
    endfunction

    // Converter FSM: next state and datapath
    always_comb begin
        state_d    = state_q;
        val_d      = val_q;
        sh_d       = sh_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        err_d      = err_q;
        start      = 1'b0;
        start_val  = sec_in;

        case (state_q)
            S_IDLE: begin
                if (sec_valid) begin
                    start     = 1'b1;
                    start_val = sec_in;
                end
            end
            S_SHIFT: begin
                scr_d = dabble_step(scr_q, sh_q[5]);
                sh_d  = {sh_q[4:0], 1'b0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd5) state_d = S_LOAD;
                if (sec_valid) begin
                    pend_d     = sec_in;
                    pend_vld_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (val_q <= 6'd59) begin
                    tens_d = scr_q[6:4];
                    ones_d = scr_q[3:0];
                    err_d  = 1'b0;
                end else begin
                    err_d  = 1'b1;
                end
                state_d = S_IDLE;
                // A queued value runs next. A strobe in this same cycle takes
                // the slot it frees. With nothing queued, a strobe starts at once.
                if (pend_vld_q) begin
                    start      = 1'b1;
                    start_val  = pend_q;
                    pend_vld_d = sec_valid;
                    if (sec_valid) pend_d = sec_in;
                end else if (sec_valid) begin
                    start     = 1'b1;
                    start_val = sec_in;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d = S_SHIFT;
            val_d   = start_val;
            sh_d    = start_val;
            scr_d   = '0;
            cnt_d   = '0;
        end
    end

    // Display multiplexer and segment selection
    always_comb begin
        mux_d   = mux_q + MUX_ONE;
        phase_d = (mux_q == '1) ? ~phase_q : phase_q;
        dsel_d  = phase_q ? 2'b10 : 2'b01;
        if (err_q) begin
            seg_d = 7'h40;
        end else if (phase_q) begin
`ifdef SECDISP_LZB_EN
            seg_d = (tens_q == 3'd0) ? 7'h00 : seg_enc({1'b0, tens_q});
`else
            seg_d = seg_enc({1'b0, tens_q});
`endif
        end else begin
            seg_d = seg_enc(ones_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            val_q      <= '0;
            sh_q       <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            tens_q     <= '0;
            ones_q     <= '0;
            err_q      <= 1'b0;
            mux_q      <= '0;
            phase_q    <= 1'b0;
            seg_q      <= '0;
            dsel_q     <= '0;
        end else begin
            state_q    <= state_d;
            val_q      <= val_d;
            sh_q       <= sh_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            err_q      <= err_d;
            mux_q      <= mux_d;
            phase_q    <= phase_d;
            seg_q      <= seg_d;
            dsel_q     <= dsel_d;
        end
    end

    assign seg       = seg_q;
    assign digit_sel = dsel_q;
    assign bcd_tens  = tens_q;
    assign bcd_ones  = ones_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule
